// File: rtl/multiplier_seq.sv
// 32x32 unsigned shift-add multiplier, one adder pass per cycle.
// Ports: clk, rst_n, start, a, b in; busy, done, product[63:0] out.

module adder_word (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_in_i,
  output logic [31:0] sum_o,
  output logic        carry_out_o
);

  assign {carry_out_o, sum_o} =
    {1'b0, a_i} + {1'b0, b_i} + {32'b0, carry_in_i};

endmodule

module multiplier_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [64:0] p_q, p_d;
  logic [31:0] m_q, m_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [31:0] add_s;
  logic        add_c;

  adder_word u_add (
    .a_i         (p_q[63:32]),
    .b_i         (m_q),
    .carry_in_i  (1'b0),
    .sum_o       (add_s),
    .carry_out_o (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a;
          p_d     = {33'b0, b};
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // P[64] is always 0 between iterations, so
        // P[64:32] is the un-added {0, upper half}.
        if (p_q[0]) begin
          p_d = {1'b0, add_c, add_s, p_q[31:1]};
        end else begin
          p_d = {1'b0, p_q[64:32], p_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = p_q[63:0];

endmodule
